key_action_gen: RTL and testbench

- Parametrised successor of the top-level key-to-action logic: N push-button channels in, per-channel action pulses and toggle LEDs out.
- Each channel has 2-FF synchronisation, counter debounce and rising-edge detection.
- Each channel has a selectable mode: single pulse, pulse with hold-to-auto-repeat, or registered level output with optional inversion.
- Sits between board keys and tetris_array's action input, replacing the inline edge-detect logic.

---
 rtl/key_action_gen.sv | 159 +++++++++++++++
 tb/tb_key_action_gen.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/key_action_gen.sv
// key_action_gen: N push-button channels turned into action pulses or levels.
// Each channel synchronises its raw key, debounces it with a stability
// counter and detects the rising edge. The rising edge then drives a single
// pulse, a pulse with hold-to-auto-repeat, or a registered (optionally
// inverted) level, depending on the channel's mode bits. An LED toggles on
// every accepted press.
module key_action_gen #(
  parameter int                  NUM_KEYS        = 4,
  parameter int                  DEBOUNCE_CYCLES = 16,
  parameter int                  REPEAT_DELAY    = 1000,
  parameter int                  REPEAT_PERIOD   = 250,
  parameter logic [NUM_KEYS-1:0] REPEAT_MASK     = 4'b1100,
  parameter logic [NUM_KEYS-1:0] LEVEL_MASK      = 4'b0001,
  parameter logic [NUM_KEYS-1:0] INVERT_MASK     = 4'b0001,
  parameter int                  CNT_W           = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_KEYS-1:0] key_in,
  output logic [NUM_KEYS-1:0] action,
  output logic [NUM_KEYS-1:0] led,
  output logic [NUM_KEYS-1:0] key_db
);

  // Terminal counts; each counter is cleared when it reaches its terminal
  // value, so none of them can wrap.
  localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] PER_LAST = CNT_W'(REPEAT_PERIOD - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  // Repeat controller states; non-repeat and level channels stay in IDLE.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DELAY = 2'd1,
    RPT   = 2'd2
  } rpt_state_e;

  for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_ch
    localparam bit IS_LEVEL  = LEVEL_MASK[gi];
    localparam bit IS_REPEAT = REPEAT_MASK[gi] & ~LEVEL_MASK[gi];
    localparam bit INV_LEVEL = INVERT_MASK[gi];

    logic             s1_q;
    logic             s2_q;
    logic             db_q;
    logic             db_d;
    logic             db_dly_q;
    logic [CNT_W-1:0] dcnt_q;
    logic [CNT_W-1:0] dcnt_d;
    logic [CNT_W-1:0] rcnt_q;
    rpt_state_e       state_q;
    logic             act_q;
    logic             led_q;
    logic             press;

    // Two-flop synchroniser for the asynchronous key level.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        s1_q <= 1'b0;
        s2_q <= 1'b0;
      end else begin
        s1_q <= key_in[gi];
        s2_q <= s1_q;
      end
    end

    // Debounce: accept the synchronised level only after it has differed
    // from the accepted state for DEBOUNCE_CYCLES consecutive cycles.
    always_comb begin
      db_d   = db_q;
      dcnt_d = '0;
      if (s2_q != db_q) begin
        if (dcnt_q == DB_LAST) begin
          db_d   = s2_q;
          dcnt_d = '0;
        end else begin
          dcnt_d = dcnt_q + CNT_ONE;
        end
      end
    end

    // Debounced state, its one-cycle delayed copy and the stability counter.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        db_q     <= 1'b0;
        db_dly_q <= 1'b0;
        dcnt_q   <= '0;
      end else begin
        db_q     <= db_d;
        db_dly_q <= db_q;
        dcnt_q   <= dcnt_d;
      end
    end

    assign press = db_q & ~db_dly_q;

    // Action generation: level follower, or press/repeat pulse controller.
    // The LED toggles only on the press itself, never on repeats.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state_q <= IDLE;
        rcnt_q  <= '0;
        act_q   <= 1'b0;
        led_q   <= 1'b0;
      end else begin
        led_q <= led_q ^ press;
        if (IS_LEVEL) begin
          act_q   <= db_q ^ INV_LEVEL;
          state_q <= IDLE;
          rcnt_q  <= '0;
        end else begin
          act_q <= 1'b0;
          case (state_q)
            IDLE: begin
              if (press) begin
                act_q   <= 1'b1;
                rcnt_q  <= '0;
                state_q <= IS_REPEAT ? DELAY : IDLE;
              end
            end
            DELAY: begin
              if (!db_q) begin
                state_q <= IDLE;
                rcnt_q  <= '0;
              end else if (rcnt_q == DLY_LAST) begin
                act_q   <= 1'b1;
                rcnt_q  <= '0;
                state_q <= RPT;
              end else begin
                rcnt_q <= rcnt_q + CNT_ONE;
              end
            end
            RPT: begin
              if (!db_q) begin
                state_q <= IDLE;
                rcnt_q  <= '0;
              end else if (rcnt_q == PER_LAST) begin
                act_q  <= 1'b1;
                rcnt_q <= '0;
              end else begin
                rcnt_q <= rcnt_q + CNT_ONE;
              end
            end
            default: begin
              state_q <= IDLE;
              rcnt_q  <= '0;
            end
          endcase
        end
      end
    end

    assign action[gi] = act_q;
    assign led[gi]    = led_q;
    assign key_db[gi] = db_q;
  end

endmodule

// File: tb/tb_key_action_gen.sv
// Testbench for key_action_gen: directed scenarios with literal expectations
// followed by randomized key activity checked every cycle against a
// behavioural model of debounce, press detection, repeat timing and LEDs.
module tb_key_action_gen;
  localparam int N  = 4;
  localparam int DB = 4;
  localparam int RD = 10;
  localparam int RP = 5;
  localparam logic [N-1:0] RMASK = 4'b1100;
  localparam logic [N-1:0] LMASK = 4'b0001;
  localparam logic [N-1:0] IMASK = 4'b0001;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] key_in = '0;
  logic [N-1:0] action;
  logic [N-1:0] led;
  logic [N-1:0] key_db;

  int checks = 0;
  int passed = 0;

  key_action_gen #(
    .NUM_KEYS(N), .DEBOUNCE_CYCLES(DB), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP),
    .REPEAT_MASK(RMASK), .LEVEL_MASK(LMASK), .INVERT_MASK(IMASK), .CNT_W(16)
  ) dut (
    .clk(clk), .rst_n(rst_n), .key_in(key_in),
    .action(action), .led(led), .key_db(key_db)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s actual=%h required=%h at %0t", name, got, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  // m_* hold the outputs expected after the most recent rising edge.
  logic [N-1:0] m_action = '0, m_led = '0, m_db = '0, m_db_prev = '0;
  int           diff_run [N];
  int           age      [N];
  bit           held     [N];
  logic [N-1:0] kq [$];

  task automatic model_reset();
    m_action = '0; m_led = '0; m_db = '0; m_db_prev = '0;
    for (int i = 0; i < N; i++) begin
      diff_run[i] = 0; age[i] = 0; held[i] = 0;
    end
    kq.delete();
  endtask

  // Advance the model by one rising edge at which key_in is sampled.
  task automatic model_step();
    logic [N-1:0] samp, n_act, n_led, n_db;
    kq.push_back(key_in);
    if (kq.size() > 3) void'(kq.pop_front());
    // Level seen by the debouncer: key_in as sampled two edges earlier.
    samp = (kq.size() >= 3) ? kq[0] : '0;
    n_act = '0; n_led = m_led; n_db = m_db;
    for (int i = 0; i < N; i++) begin
      bit press;
      press = m_db[i] & ~m_db_prev[i];
      // Accept a change once it has persisted DB consecutive samples.
      if (samp[i] != m_db[i]) begin
        diff_run[i]++;
        if (diff_run[i] == DB) begin
          n_db[i] = samp[i];
          diff_run[i] = 0;
        end
      end else begin
        diff_run[i] = 0;
      end
      if (press) n_led[i] = ~m_led[i];
      if (LMASK[i]) begin
        n_act[i] = m_db[i] ^ IMASK[i];
      end else if (press) begin
        n_act[i] = 1'b1;
        held[i] = 1;
        age[i] = 0;
      end else if (held[i]) begin
        if (m_db[i]) begin
          age[i]++;
          // Pulses at RD edges after the press, then every RP edges.
          if (RMASK[i] && (age[i] == RD || (age[i] > RD && (age[i] - RD) % RP == 0)))
            n_act[i] = 1'b1;
        end else begin
          held[i] = 0;
        end
      end
    end
    m_db_prev = m_db;
    m_db = n_db;
    m_action = n_act;
    m_led = n_led;
  endtask

  // Compare process: checks outputs every cycle on the falling edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      model_reset();
      check("reset_outputs", {action, led, key_db}, '0);
    end else begin
      check("action", action, m_action);
      check("led", led, m_led);
      check("key_db", key_db, m_db);
      model_step();
    end
  end

  // ---------------- stimulus ----------------
  logic [63:0] got_v, exp_v;
  int          cnt [N];

  task automatic wait_edges(input int n);
    repeat (n) @(posedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    key_in = '0;
    #1;
    check("por_all_zero", {action, led, key_db}, '0);
    wait_edges(3); #2 rst_n = 1'b1;
    @(posedge clk); #3;
    check("level_first_clock", action[0], 1'b1);
    wait_edges(5);

    // Scenario 1: key 3 press timing.
    @(posedge clk); #2 key_in[3] = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      @(posedge clk); #3;
      if (e == 5) check("s1_db_before", key_db[3], 1'b0);
      if (e == 6) begin
        check("s1_db_at6", key_db[3], 1'b1);
        check("s1_act_at6", action[3], 1'b0);
      end
      if (e == 7) begin
        check("s1_act_at7", action[3], 1'b1);
        check("s1_led_at7", led[3], 1'b1);
      end
      if (e == 8) check("s1_act_at8", action[3], 1'b0);
    end
    key_in[3] = 1'b0;
    wait_edges(30);

    // Scenario 2: key 2 held 40 cycles with auto-repeat.
    got_v = '0; exp_v = '0;
    exp_v[7] = 1; exp_v[17] = 1; exp_v[22] = 1; exp_v[27] = 1;
    exp_v[32] = 1; exp_v[37] = 1; exp_v[42] = 1;
    @(posedge clk); #2 key_in[2] = 1'b1;
    for (int e = 1; e <= 63; e++) begin
      @(posedge clk); #3;
      got_v[e] = action[2];
      if (e == 40) key_in[2] = 1'b0;
    end
    check("s2_repeat_pulses", got_v, exp_v);
    check("s2_led_once", led[2], 1'b1);

    // Scenario 3: key 1 held 40 cycles, no auto-repeat.
    got_v = '0; exp_v = '0; exp_v[7] = 1;
    @(posedge clk); #2 key_in[1] = 1'b1;
    for (int e = 1; e <= 63; e++) begin
      @(posedge clk); #3;
      got_v[e] = action[1];
      if (e == 40) key_in[1] = 1'b0;
    end
    check("s3_single_pulse", got_v, exp_v);

    // Scenario 4: 3-cycle glitch and a 1-cycle bounce on key 3.
    got_v = '0;
    @(posedge clk); #2 key_in[3] = 1'b1;
    for (int e = 1; e <= 24; e++) begin
      @(posedge clk); #3;
      got_v[e] = key_db[3] | action[3];
      case (e)
        3:  key_in[3] = 1'b0;
        6:  key_in[3] = 1'b1;
        7:  key_in[3] = 1'b0;
        8:  key_in[3] = 1'b1;
        9:  key_in[3] = 1'b0;
        default: ;
      endcase
    end
    check("s4_glitch_ignored", got_v, 64'd0);
    check("s4_led_kept", led[3], 1'b1);

    // Scenario 5: level channel 0 with inversion.
    @(posedge clk); #2 key_in[0] = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      @(posedge clk); #3;
      if (e == 6) check("s5_act_at6", action[0], 1'b1);
      if (e == 7) begin
        check("s5_act_at7", action[0], 1'b0);
        check("s5_led_at7", led[0], 1'b1);
      end
    end
    key_in[0] = 1'b0;
    wait_edges(20);

    // Scenario 6: reset while key 2 is held, then a fresh press.
    @(posedge clk); #2 key_in[2] = 1'b1;
    wait_edges(20); #2 rst_n = 1'b0;
    #1 check("s6_reset_immediate", {action, led, key_db}, '0);
    wait_edges(2); #2 rst_n = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      @(posedge clk); #3;
      if (e == 6) check("s6_act_at6", action[2], 1'b0);
      if (e == 7) begin
        check("s6_act_at7", action[2], 1'b1);
        check("s6_led_at7", led[2], 1'b1);
      end
    end
    key_in[2] = 1'b0;
    wait_edges(30);

    // Randomized phase: mixed holds, glitches and occasional resets.
    for (int i = 0; i < N; i++) cnt[i] = $urandom_range(1, 30);
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #2;
      if ($urandom_range(0, 599) == 0) begin
        rst_n = 1'b0;
        wait_edges($urandom_range(1, 3)); #2;
        rst_n = 1'b1;
      end
      for (int i = 0; i < N; i++) begin
        if (cnt[i] == 0) begin
          key_in[i] = ~key_in[i];
          cnt[i] = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 4) : $urandom_range(5, 45);
        end else begin
          cnt[i]--;
        end
      end
    end
    key_in = '0;
    wait_edges(50);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
